// File: rtl/shot_blank_ctrl_if.sv
// ---------------------------------------------------------------------------
// shot_blank_ctrl_if
// Groups the shot-blanking controller's sensor/control inputs and its
// display-facing outputs into one bundle.
//
//   shot        : raw, asynchronous shot sensor level (to controller)
//   enable      : arms hit acceptance when high (to controller)
//   clear       : one-cycle restore request (to controller)
//   blank       : per-digit blank mask, bit0 = seconds-units .. bit5 = hours-tens
//   hit_count   : number of accepted hits, 0..6
//   hit_pulse   : one-cycle strobe per accepted hit
//   all_blanked : high while every digit is blanked and held
//
// master : the side that drives shot/enable/clear (sensor and control logic)
// slave  : the controller itself
// ---------------------------------------------------------------------------
interface shot_blank_ctrl_if;
   logic       shot;
   logic       enable;
   logic       clear;
   logic [5:0] blank;
   logic [2:0] hit_count;
   logic       hit_pulse;
   logic       all_blanked;

   modport master (
      output shot,
      output enable,
      output clear,
      input  blank,
      input  hit_count,
      input  hit_pulse,
      input  all_blanked
   );

   modport slave (
      input  shot,
      input  enable,
      input  clear,
      output blank,
      output hit_count,
      output hit_pulse,
      output all_blanked
   );
endinterface

// File: rtl/shot_blank_ctrl.sv
// ---------------------------------------------------------------------------
// shot_blank_ctrl
// Sequences the clock display's shot-blanking feature. The raw shot input is
// synchronized into the shotClk domain and each rising edge is accepted as one
// hit while armed. Hits blank the six display digits one at a time, starting
// with seconds-units and ending with hours-tens. A lockout window follows each
// hit. After the sixth hit the all-blanked state is held and then either
// restored automatically after HOLD_CYCLES or held until clear.
//
// Parameters:
//   LOCKOUT_CYCLES : cycles after an accepted hit during which edges are ignored (>= 1)
//   HOLD_CYCLES    : cycles spent all-blanked before auto-restore (>= 1)
//   AUTO_CLEAR     : 1 = auto-restore after HOLD_CYCLES, 0 = hold until clear
//
// Ports:
//   shotClk : block clock
//   shotRst : asynchronous, active-low reset
//   bus     : slave side of shot_blank_ctrl_if (shot/enable/clear in,
//             blank/hit_count/hit_pulse/all_blanked out)
// ---------------------------------------------------------------------------
module shot_blank_ctrl #(
   parameter int LOCKOUT_CYCLES = 16,
   parameter int HOLD_CYCLES    = 1024,
   parameter bit AUTO_CLEAR     = 1'b1
) (
   input  logic              shotClk,
   input  logic              shotRst,
   shot_blank_ctrl_if.slave  bus
);

   // One shared down-counter serves both the lockout and the hold window, so
   // it is sized for whichever of the two is longer.
   localparam int MAX_CYCLES = (LOCKOUT_CYCLES > HOLD_CYCLES) ? LOCKOUT_CYCLES : HOLD_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   localparam logic [2:0] LAST_HIT_IDX = 3'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      LOCKOUT = 2'd2,
      DONE    = 2'd3
   } state_t;

   logic             s1;
   logic             s2;
   logic             s2_d;
   logic             shot_edge;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [5:0]       blank_q;
   logic [5:0]       blank_next;
   logic [2:0]       count_q;
   logic [2:0]       count_next;
   logic             pulse_q;
   logic             pulse_next;

   // Two-flop synchronizer plus one delay stage for edge detection. These run
   // regardless of FSM state, so a shot held high produces a single edge no
   // matter when the FSM becomes ready to accept it.
   always_ff @(posedge shotClk or negedge shotRst) begin
      if (!shotRst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s2_d <= 1'b0;
      end else begin
         s1   <= bus.shot;
         s2   <= s1;
         s2_d <= s2;
      end
   end

   assign shot_edge = s2 & ~s2_d;

   // State register and the registered outputs. Everything is discarded on
   // reset, including any lockout or hold already in progress.
   always_ff @(posedge shotClk or negedge shotRst) begin
      if (!shotRst) begin
         state   <= IDLE;
         cnt     <= '0;
         blank_q <= '0;
         count_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         blank_q <= blank_next;
         count_q <= count_next;
         pulse_q <= pulse_next;
      end
   end

   // Next-state and next-output logic. clear is checked first so it beats a
   // same-cycle edge and a same-cycle counter expiry. The counter is loaded
   // only on entry to LOCKOUT/DONE and stops at zero, so it never wraps.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      blank_next = blank_q;
      count_next = count_q;
      pulse_next = 1'b0;

      if (bus.clear) begin
         blank_next = '0;
         count_next = '0;
         state_next = bus.enable ? ARMED : IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.enable) begin
                  state_next = ARMED;
               end
            end

            ARMED: begin
               // Dropping enable wins over a coincident edge.
               if (!bus.enable) begin
                  state_next = IDLE;
               end else if (shot_edge) begin
                  blank_next = blank_q | (6'b000001 << count_q);
                  count_next = count_q + 3'd1;
                  pulse_next = 1'b1;
                  if (count_q >= LAST_HIT_IDX) begin
                     state_next = DONE;
                     cnt_next   = AUTO_CLEAR ? HOLD_LOAD : '0;
                  end else begin
                     state_next = LOCKOUT;
                     cnt_next   = LOCK_LOAD;
                  end
               end
            end

            LOCKOUT: begin
               if (cnt == '0) begin
                  state_next = bus.enable ? ARMED : IDLE;
               end else begin
                  cnt_next = cnt - 1'b1;
               end
            end

            DONE: begin
               // Without auto-restore only clear (handled above) leaves DONE.
               if (AUTO_CLEAR) begin
                  if (cnt == '0) begin
                     blank_next = '0;
                     count_next = '0;
                     state_next = bus.enable ? ARMED : IDLE;
                  end else begin
                     cnt_next = cnt - 1'b1;
                  end
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign bus.blank       = blank_q;
   assign bus.hit_count   = count_q;
   assign bus.hit_pulse   = pulse_q;
   assign bus.all_blanked = (state == DONE);

   // The mask is filled strictly from bit0 upward, one bit per hit.
   a_blank_matches_count : assert property (
      @(posedge shotClk) disable iff (!shotRst)
      ({1'b0, blank_q} == ((7'd1 << count_q) - 7'd1)) && (count_q <= 3'd6)
   );

endmodule
